regfile_dump_tx: RTL

Debug-side reader for the register file's flat debug bus. On a dump request it snapshots all registers from the 1024-bit `o_debug_regs` bus of `RegisterFile` and streams them out as 128 bytes over a valid/ready byte handshake to the debug UART transmitter. It sits between the datapath's register file and the debug unit's serial TX path, and runs concurrently with the processor. The snapshot is taken once per dump, so later register writes do not corrupt an in-flight dump.

---
 rtl/regfile_dump_tx_pkg.sv | 20 ++
 rtl/regfile_dump_tx.sv | 80 ++++++++
 2 files changed

// File: rtl/regfile_dump_tx_pkg.sv
// Shared constants and FSM encodings for the register-file debug dump path.
// The debug unit imports this to decode the dump FSM state.
package regfile_dump_tx_pkg;

   localparam int unsigned DUMP_PROC_BITS = 32;
   localparam int unsigned DUMP_REG_COUNT = DUMP_PROC_BITS;
   localparam int unsigned DUMP_BYTE_BITS = 8;

   // Raw encodings, exported so other blocks can decode the state without the enum type.
   localparam logic [1:0] DUMP_IDLE = 2'd0;
   localparam logic [1:0] DUMP_SEND = 2'd1;
   localparam logic [1:0] DUMP_DONE = 2'd2;

   typedef enum logic [1:0] {
      DumpIdle = DUMP_IDLE,
      DumpSend = DUMP_SEND,
      DumpDone = DUMP_DONE
   } dump_state_e;

endpackage

// File: rtl/regfile_dump_tx.sv
// Snapshots the flat register-file debug bus on request and streams it out
// byte by byte (register 0 first, little-endian within a register) over a
// valid/ready handshake towards the debug UART transmitter.
module regfile_dump_tx
   import regfile_dump_tx_pkg::*;
#(
   parameter int unsigned PROC_BITS = DUMP_PROC_BITS,
   parameter int unsigned REG_COUNT = PROC_BITS,
   parameter int unsigned BYTE_BITS = DUMP_BYTE_BITS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_start,
   input  logic [PROC_BITS*REG_COUNT-1:0] i_debug_regs,
   output logic [BYTE_BITS-1:0]           o_tx_data,
   output logic                           o_tx_valid,
   input  logic                           i_tx_ready,
   output logic                           o_busy,
   output logic                           o_done
);

   localparam int unsigned TOTAL_BITS = PROC_BITS * REG_COUNT;
   localparam int unsigned NBYTES     = TOTAL_BITS / BYTE_BITS;
   localparam int unsigned CNT_W      = $clog2(NBYTES);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

   dump_state_e             state;
   logic [TOTAL_BITS-1:0]   snap;
   logic [CNT_W-1:0]        byte_cnt;

   // The byte on offer is always the low end of the snapshot shift register.
   assign o_tx_data = snap[BYTE_BITS-1:0];

   // Dump FSM: snapshot on start, shift out one byte per accepted handshake,
   // one-cycle done pulse, then back to idle. Outputs are registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= DumpIdle;
         snap       <= '0;
         byte_cnt   <= '0;
         o_tx_valid <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         unique case (state)
            DumpIdle: begin
               if (i_start) begin
                  snap       <= i_debug_regs;
                  byte_cnt   <= '0;
                  o_tx_valid <= 1'b1;
                  o_busy     <= 1'b1;
                  state      <= DumpSend;
               end
            end
            DumpSend: begin
               if (i_tx_ready) begin
                  snap     <= snap >> BYTE_BITS;
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == LAST_IDX) begin
                     o_tx_valid <= 1'b0;
                     o_done     <= 1'b1;
                     state      <= DumpDone;
                  end
               end
            end
            DumpDone: begin
               o_busy <= 1'b0;
               state  <= DumpIdle;
            end
            default: begin
               o_tx_valid <= 1'b0;
               o_busy     <= 1'b0;
               state      <= DumpIdle;
            end
         endcase
      end
   end

endmodule
